// File: rtl/multicycle_ctrl_pkg.sv
// Purpose : shared encodings for the multicycle MIPS-subset control unit (opcodes, funct, ALU codes, FSM states, mux selects).
// Latency : n/a (constants and types only).
// Backpressure: n/a.
package ctrl_pkg;

  // Instruction opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct field, instr[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes, shared with the ALU itself
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALU operand B select
  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Purpose : bundles the instruction fields, ALU flag and all datapath controls between control unit and datapath.
// Latency : n/a (wires only).
// Backpressure: none; controls are valid every cycle.
// Ports   : master = control unit (drives controls, reads opcode/funct/zero);
//           slave  = datapath (drives opcode/funct/zero, reads controls).
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alu_ctrl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       iord;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;

  modport master (
    input  opcode, funct, zero,
    output alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, iord,
           ir_write, mem_write, reg_write, reg_dst, mem_to_reg, illegal
  );

  modport slave (
    output opcode, funct, zero,
    input  alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, iord,
           ir_write, mem_write, reg_write, reg_dst, mem_to_reg, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// Purpose : R-type funct to ALU operation decode, with a flag for supported funct values.
// Latency : combinational.
// Backpressure: none.
// Ports   : funct in [5:0]; alu_ctrl out [2:0]; funct_legal out (1 = supported funct).
module alu_dec
  import ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_legal
);

  always_comb begin
    alu_ctrl    = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose : Moore FSM sequencing a MIPS-subset instruction through fetch/decode/execute/memory/writeback.
// Latency : 2 (illegal) to 5 (lw) cycles per instruction; one state per clock.
// Backpressure: none; the FSM advances every clock, synchronous reset aborts any instruction.
// Ports   : clk, reset (sync, active-high); bus = multicycle_ctrl_if.master carrying opcode/funct/zero
//           in and alu_ctrl, mux selects, pc_en, write strobes and illegal out.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] fn_alu_ctrl;
  logic       fn_legal;
  logic       pc_write;
  logic       branch;

  alu_dec u_alu_dec (
    .funct       (bus.funct),
    .alu_ctrl    (fn_alu_ctrl),
    .funct_legal (fn_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.alu_ctrl   = ALU_ADD;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_REGB;
    bus.pc_src     = PCSRC_ALU;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal    = 1'b0;
    pc_write       = 1'b0;
    branch         = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.alu_src_b = SRCB_FOUR;
        bus.ir_write  = 1'b1;
        pc_write      = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here so BRANCH only needs the compare.
        bus.alu_src_b = SRCB_IMM_SH;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (fn_legal) state_d = S_EXECUTE;
            else begin
              state_d     = S_FETCH;
              bus.illegal = 1'b1;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: begin
            state_d     = S_FETCH;
            bus.illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        state_d       = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.iord = 1'b1;
        state_d  = S_MEMWB;
      end
      S_MEMWB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXECUTE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = fn_alu_ctrl;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = ALU_SUB;
        bus.pc_src    = PCSRC_ALUOUT;
        branch        = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        state_d       = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_src = PCSRC_JUMP;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // While reset is asserted the datapath sees a quiet FETCH: selects as in
    // FETCH, but no strobe may fire and no illegal pulse may escape.
    if (reset) begin
      state_d        = S_FETCH;
      bus.alu_ctrl   = ALU_ADD;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = SRCB_FOUR;
      bus.pc_src     = PCSRC_ALU;
      bus.iord       = 1'b0;
      bus.ir_write   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.illegal    = 1'b0;
      pc_write       = 1'b0;
      branch         = 1'b0;
    end

    // zero comes straight from this cycle's SUB, so beq resolves without a register stage.
    bus.pc_en = pc_write | (branch & bus.zero);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } exp_t;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  exp_t  exp_q[$];
  string tag_q[$];

  multicycle_ctrl_if ifc ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (spec-level) ----------------
  function automatic exp_t quiet();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t reset_vec();
    exp_t e;
    e = quiet();
    e.alu_src_b = 2'b01;
    return e;
  endfunction

  function automatic exp_t fetch_vec();
    exp_t e;
    e = quiet();
    e.alu_src_b = 2'b01;
    e.ir_write  = 1'b1;
    e.pc_en     = 1'b1;
    return e;
  endfunction

  function automatic bit rtype_alu(input logic [5:0] fn, output logic [2:0] op);
    op = 3'b000;
    if (fn == 6'b100000) begin op = 3'b000; return 1; end
    if (fn == 6'b100010) begin op = 3'b001; return 1; end
    if (fn == 6'b100100) begin op = 3'b010; return 1; end
    if (fn == 6'b100101) begin op = 3'b011; return 1; end
    if (fn == 6'b101010) begin op = 3'b101; return 1; end
    return 0;
  endfunction

  function automatic bit op_known(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input exp_t e, input string tag, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input logic rst);
    @(posedge clk);
    #1;
    reset      = rst;
    ifc.opcode = op;
    ifc.funct  = fn;
    ifc.zero   = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++)
      step(reset_vec(), "reset", 6'($urandom), 6'($urandom), 1'($urandom), 1'b1);
  endtask

  // Runs one instruction; when abort_at matches a phase index, that phase is
  // replaced by two reset cycles and the instruction is abandoned.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int abort_at);
    exp_t   v[$];
    string  t[$];
    bit     hold[$];
    bit     is_br[$];
    exp_t   e;
    logic [2:0] aop;
    bit     fn_ok;
    bit     legal;

    fn_ok = rtype_alu(fn, aop);
    legal = op_known(op) && (op != 6'b000000 || fn_ok);

    v.push_back(fetch_vec()); t.push_back("fetch"); hold.push_back(0); is_br.push_back(0);
    e = quiet(); e.alu_src_b = 2'b11; e.illegal = !legal;
    v.push_back(e); t.push_back("decode"); hold.push_back(1); is_br.push_back(0);

    if (legal) begin
      case (op)
        6'b100011, 6'b101011: begin
          e = quiet(); e.alu_src_a = 1; e.alu_src_b = 2'b10;
          v.push_back(e); t.push_back("memadr"); hold.push_back(1); is_br.push_back(0);
          if (op == 6'b100011) begin
            e = quiet(); e.iord = 1;
            v.push_back(e); t.push_back("memrd"); hold.push_back(0); is_br.push_back(0);
            e = quiet(); e.mem_to_reg = 1; e.reg_write = 1;
            v.push_back(e); t.push_back("memwb"); hold.push_back(0); is_br.push_back(0);
          end else begin
            e = quiet(); e.iord = 1; e.mem_write = 1;
            v.push_back(e); t.push_back("memwr"); hold.push_back(0); is_br.push_back(0);
          end
        end
        6'b000000: begin
          e = quiet(); e.alu_src_a = 1; e.alu_ctrl = aop;
          v.push_back(e); t.push_back("execute"); hold.push_back(1); is_br.push_back(0);
          e = quiet(); e.reg_dst = 1; e.reg_write = 1;
          v.push_back(e); t.push_back("aluwb"); hold.push_back(0); is_br.push_back(0);
        end
        6'b000100: begin
          e = quiet(); e.alu_src_a = 1; e.alu_ctrl = 3'b001; e.pc_src = 2'b01;
          v.push_back(e); t.push_back("branch"); hold.push_back(0); is_br.push_back(1);
        end
        6'b001000: begin
          e = quiet(); e.alu_src_a = 1; e.alu_src_b = 2'b10;
          v.push_back(e); t.push_back("addiex"); hold.push_back(0); is_br.push_back(0);
          e = quiet(); e.reg_write = 1;
          v.push_back(e); t.push_back("addiwb"); hold.push_back(0); is_br.push_back(0);
        end
        default: begin
          e = quiet(); e.pc_src = 2'b10; e.pc_en = 1;
          v.push_back(e); t.push_back("jump"); hold.push_back(0); is_br.push_back(0);
        end
      endcase
    end

    for (int i = 0; i < v.size(); i++) begin
      logic z;
      if (i == abort_at) begin
        reset_cycles(2);
        return;
      end
      z = 1'($urandom);
      e = v[i];
      if (is_br[i]) e.pc_en = z;
      step(e, t[i], hold[i] ? op : 6'($urandom), hold[i] ? fn : 6'($urandom), z, 1'b0);
    end
  endtask

  task automatic run_beq(input logic z_fixed);
    exp_t e;
    step(fetch_vec(), "fetch", 6'($urandom), 6'($urandom), 1'($urandom), 1'b0);
    e = quiet(); e.alu_src_b = 2'b11;
    step(e, "decode", 6'b000100, 6'($urandom), 1'($urandom), 1'b0);
    e = quiet(); e.alu_src_a = 1; e.alu_ctrl = 3'b001; e.pc_src = 2'b01; e.pc_en = z_fixed;
    step(e, "branch", 6'($urandom), 6'($urandom), z_fixed, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        exp_t  e;
        exp_t  g;
        string tg;
        e  = exp_q.pop_front();
        tg = tag_q.pop_front();
        g.alu_ctrl   = ifc.alu_ctrl;
        g.alu_src_a  = ifc.alu_src_a;
        g.alu_src_b  = ifc.alu_src_b;
        g.pc_src     = ifc.pc_src;
        g.pc_en      = ifc.pc_en;
        g.iord       = ifc.iord;
        g.ir_write   = ifc.ir_write;
        g.mem_write  = ifc.mem_write;
        g.reg_write  = ifc.reg_write;
        g.reg_dst    = ifc.reg_dst;
        g.mem_to_reg = ifc.mem_to_reg;
        g.illegal    = ifc.illegal;
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL %s cycle=%0d got alu=%b a=%b b=%b pcs=%b pcen=%b iord=%b irw=%b memw=%b regw=%b dst=%b m2r=%b ill=%b | exp alu=%b a=%b b=%b pcs=%b pcen=%b iord=%b irw=%b memw=%b regw=%b dst=%b m2r=%b ill=%b",
                   tg, cyc,
                   g.alu_ctrl, g.alu_src_a, g.alu_src_b, g.pc_src, g.pc_en, g.iord, g.ir_write,
                   g.mem_write, g.reg_write, g.reg_dst, g.mem_to_reg, g.illegal,
                   e.alu_ctrl, e.alu_src_a, e.alu_src_b, e.pc_src, e.pc_en, e.iord, e.ir_write,
                   e.mem_write, e.reg_write, e.reg_dst, e.mem_to_reg, e.illegal);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    reset      = 1'b1;
    ifc.opcode = '0;
    ifc.funct  = '0;
    ifc.zero   = 1'b0;

    reset_cycles(2);

    // lw aborted by two reset cycles while in MEMRD, then a full lw
    run_instr(6'b100011, 6'($urandom), 3);
    run_instr(6'b100011, 6'($urandom), -1);
    // R-type SLT then SUB
    run_instr(6'b000000, 6'b101010, -1);
    run_instr(6'b000000, 6'b100010, -1);
    // beq taken / not taken
    run_beq(1'b1);
    run_beq(1'b0);
    // illegal opcode and illegal funct
    run_instr(6'b111111, 6'($urandom), -1);
    run_instr(6'b000000, 6'b000111, -1);
    // sw then j
    run_instr(6'b101011, 6'($urandom), -1);
    run_instr(6'b000010, 6'($urandom), -1);
    // addi, remaining R-type ops
    run_instr(6'b001000, 6'($urandom), -1);
    run_instr(6'b000000, 6'b100000, -1);
    run_instr(6'b000000, 6'b100100, -1);
    run_instr(6'b000000, 6'b100101, -1);

    // Randomized instruction mix with occasional mid-instruction resets
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      logic [2:0] dummy;
      int         ab;
      fn = 6'($urandom);
      case ($urandom_range(0, 7))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin
          op = 6'b000000;
          case ($urandom_range(0, 4))
            0: fn = 6'b100000;
            1: fn = 6'b100010;
            2: fn = 6'b100100;
            3: fn = 6'b100101;
            default: fn = 6'b101010;
          endcase
        end
        3: begin
          op = 6'b000000;
          while (rtype_alu(fn, dummy)) fn = 6'($urandom);
        end
        4: op = 6'b000100;
        5: op = 6'b001000;
        6: op = 6'b000010;
        default: begin
          op = 6'($urandom);
          while (op_known(op)) op = 6'($urandom);
        end
      endcase
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(op, fn, ab);
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit that drives the ALU's `alu_ctrl` port and every datapath enable for a MIPS-subset core. It replaces single-cycle combinational control with a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback states. It consumes opcode/funct from the instruction register and the ALU `zero` flag. It produces register, memory and PC strobes one state per clock.

## Interface
- No parameters; all encodings are fixed constants in `ctrl_pkg`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high; takes effect on the rising edge of `clk`.
- `opcode` in 6: instr[31:26] from the instruction register; stable from DECODE until FETCH.
- `funct` in 6: instr[5:0]; same stability as `opcode`.
- `zero` in 1: ALU zero flag (1 when ALU_result == 0).
- `alu_ctrl` out 3: ADD=000, SUB=001, AND=010, OR=011, SLT=101.
- `alu_src_a` out 1: 0=PC, 1=regA.
- `alu_src_b` out 2: 00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- `pc_src` out 2: 00=ALU_result, 01=ALUOut register, 10=jump target.
- `pc_en` out 1: PC load enable, equal to pc_write | (branch & zero).
- `iord` out 1: memory address select, 0=PC, 1=ALUOut.
- `ir_write`, `mem_write`, `reg_write` out 1 each: write strobes.
- `reg_dst` out 1: 0=rt, 1=rd.
- `mem_to_reg` out 1: 0=ALUOut, 1=memory data.
- `illegal` out 1: one-cycle pulse when an unsupported instruction is decoded.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Transitions:
  - FETCH always goes to DECODE.
  - DECODE goes to MEMADR (lw 100011, sw 101011), EXECUTE (R-type 000000 with legal funct), BRANCH (beq 000100), ADDIEX (addi 001000) or JUMP (j 000010). Anything else returns to FETCH with `illegal`=1 for that DECODE cycle.
  - MEMADR goes to MEMRD (lw) or MEMWR (sw).
  - MEMRD goes to MEMWB; EXECUTE goes to ALUWB; ADDIEX goes to ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP all return to FETCH.
- Moore outputs; every signal not listed for a state is 0, and `alu_ctrl` defaults to ADD:
  - FETCH: iord=0, src_a=0, src_b=01, ADD, pc_src=00, ir_write=1, pc_write=1.
  - DECODE: src_a=0, src_b=11, ADD (precomputes the branch target).
  - MEMADR: src_a=1, src_b=10, ADD.
  - MEMRD: iord=1.
  - MEMWR: iord=1, mem_write=1.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
  - EXECUTE: src_a=1, src_b=00, `alu_ctrl` from the funct decode.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1.
  - BRANCH: src_a=1, src_b=00, SUB, pc_src=01, branch=1.
  - ADDIEX: src_a=1, src_b=10, ADD.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
  - JUMP: pc_src=10, pc_write=1.
- Funct decode:
  - 100000 gives ADD; 100010 gives SUB; 100100 gives AND; 100101 gives OR; 101010 gives SLT.
  - Any other funct with R-type is illegal and is caught in DECODE.
- `branch` and `pc_write` are internal signals; only `pc_en` leaves the block.

## Timing
- Reset:
  - Next state is FETCH regardless of current state, including mid-instruction. No partial instruction completes.
  - While `reset` is sampled high, all strobes (`ir_write`, `mem_write`, `reg_write`, `pc_en`) and `illegal` are forced to 0.
  - Mux selects and `alu_ctrl` take their FETCH values during reset.
- Cycles per instruction, FETCH through the final state:
  - lw 5; sw 4; R-type 4; addi 4.
  - beq 3; j 3.
  - illegal 2.
- `pc_en` in BRANCH is combinational from `zero`. Same-cycle ALU SUB result on regA/regB gates the PC load; no registered delay.
- `opcode`/`funct` are only examined in DECODE, MEMADR and EXECUTE. Changes at other times have no effect.
- Exactly one of `ir_write`/`mem_write`/`reg_write` can be high in any cycle. `pc_en` can coincide only with `ir_write` (FETCH).

## Structure
- `ctrl_pkg`: opcode and funct constants, ALU code constants (shared with the ALU), the state encoding, and the src_b/pc_src select constants.
- Sub-module `alu_dec`: combinational funct-to-`alu_ctrl` decode plus a legal flag. It is instantiated in `multicycle_ctrl` and reused by any later pipeline control.
- Main module holds the state register, next-state logic and the output decode.

## Test plan
- Reset held for 2 cycles in MEMRD, then released → state FETCH; `ir_write`=1 and `pc_en`=1 in the first post-reset cycle; `reg_write` never asserted for the aborted lw.
- lw (opcode 100011) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; `iord`=1 in MEMRD; `mem_to_reg`=1 and `reg_write`=1 in MEMWB only.
- R-type with funct 101010, then 100010 → `alu_ctrl`=101 in EXECUTE for the first, 001 for the second; `reg_dst`=1 in ALUWB; 4 cycles each.
- beq with `zero`=1, then with `zero`=0 in BRANCH → `pc_en`=1 with `pc_src`=01 for the first; `pc_en`=0 for the second; both return to FETCH after 3 cycles.
- opcode 111111, and R-type with funct 000111 → `illegal`=1 for one cycle in DECODE; next state FETCH; no write strobe asserted.
- sw followed by j → `mem_write`=1 only in MEMWR; JUMP drives `pc_src`=10 with `pc_en`=1; instruction count matches 4+3 cycles.
